uart_boot_loader: RTL and testbench

//  Sequencer behind the UART byte receiver. Consumes received bytes, parses a length-prefixed

---
 rtl/uart_boot_loader_if.sv | 29 ++
 rtl/uart_boot_loader.sv | 179 +++++++++++++++++
 tb/tb_uart_boot_loader.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_if.sv
// Byte-stream, re-arm, instruction-memory write port and status lines
// between the UART receiver, the boot loader and the top level.
// The slave modport is the loader; the master modport is whatever feeds it
// bytes and watches the memory writes and status.
interface uart_boot_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  io_data_valid;
    logic [7:0]            io_data_packet;
    logic                  io_load_start;
    logic                  io_mem_we;
    logic [ADDR_WIDTH-1:0] io_mem_addr;
    logic [31:0]           io_mem_wdata;
    logic                  io_cpu_reset_n;
    logic                  io_load_done;
    logic                  io_load_error;

    modport master (
        output io_data_valid, io_data_packet, io_load_start,
        input  io_mem_we, io_mem_addr, io_mem_wdata,
        input  io_cpu_reset_n, io_load_done, io_load_error
    );

    modport slave (
        input  io_data_valid, io_data_packet, io_load_start,
        output io_mem_we, io_mem_addr, io_mem_wdata,
        output io_cpu_reset_n, io_load_done, io_load_error
    );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: parses a length-prefixed image (16-bit little-endian word
// count, then 4 bytes per word LSB first), writes the packed words into
// instruction memory and holds the core in reset until the image is in.
// Optional feature macro: UART_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte that must cancel the XOR of all payload bytes.
module uart_boot_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input logic         clk,
    input logic         reset_n,
    uart_boot_loader_if.slave bus
);
    localparam int          GAP_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        LEN_LO  = 3'd0,
        LEN_HI  = 3'd1,
        PAYLOAD = 3'd2,
        DONE    = 3'd3,
`ifdef UART_LOADER_CHECKSUM_EN
        CHECK   = 3'd5,
`endif
        ERROR   = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [7:0]            len_lo;
    logic [15:0]           len;
    logic [15:0]           len_in;
    logic [1:0]            byte_idx;
    logic [23:0]           word_buf;
    logic [16:0]           word_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  take_len_lo, take_len_hi, take_payload, rearm, gap_run;
    logic                  timeout_hit;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    assign len_in      = {bus.io_data_packet, len_lo};
    assign timeout_hit = (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1));

    assign bus.io_mem_we      = mem_we;
    assign bus.io_mem_addr    = mem_addr;
    assign bus.io_mem_wdata   = mem_wdata;
    assign bus.io_load_done   = (state == DONE);
    assign bus.io_load_error  = (state == ERROR);
    assign bus.io_cpu_reset_n = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= LEN_LO;
        else          state <= state_nxt;
    end

    // Frame parsing: next state plus the strobes that steer the datapath
    always_comb begin
        state_nxt    = state;
        take_len_lo  = 1'b0;
        take_len_hi  = 1'b0;
        take_payload = 1'b0;
        rearm        = 1'b0;
        gap_run      = 1'b0;
        unique case (state)
            LEN_LO: begin
                if (bus.io_data_valid) begin
                    take_len_lo = 1'b1;
                    state_nxt   = LEN_HI;
                end
            end
            LEN_HI: begin
                gap_run = 1'b1;
                if (bus.io_data_valid) begin
                    take_len_hi = 1'b1;
                    if (len_in == 16'd0)
`ifdef UART_LOADER_CHECKSUM_EN
                        state_nxt = CHECK;
`else
                        state_nxt = DONE;
`endif
                    else if ({1'b0, len_in} > MAX_WORDS)
                        state_nxt = ERROR;
                    else
                        state_nxt = PAYLOAD;
                end else if (timeout_hit) begin
                    state_nxt = ERROR;
                end
            end
            PAYLOAD: begin
                gap_run = 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                if (bus.io_data_valid) begin
                    take_payload = 1'b1;
                    if (byte_idx == 2'd3 && (word_cnt + 17'd1) == {1'b0, len})
                        state_nxt = CHECK;
                end else if (timeout_hit) begin
                    state_nxt = ERROR;
                end
`else
                if (mem_we && word_cnt == {1'b0, len})
                    state_nxt = DONE;
                else if (bus.io_data_valid)
                    take_payload = 1'b1;
                else if (timeout_hit)
                    state_nxt = ERROR;
`endif
            end
`ifdef UART_LOADER_CHECKSUM_EN
            CHECK: begin
                gap_run = 1'b1;
                if (bus.io_data_valid)
                    state_nxt = ((csum ^ bus.io_data_packet) == 8'h00) ? DONE : ERROR;
                else if (timeout_hit)
                    state_nxt = ERROR;
            end
`endif
            DONE, ERROR: begin
                if (bus.io_load_start) begin
                    rearm     = 1'b1;
                    state_nxt = LEN_LO;
                end
            end
            default: state_nxt = LEN_LO;
        endcase
    end

    // Datapath: length capture, byte packing, memory write pulse, gap timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_lo    <= '0;
            len       <= '0;
            byte_idx  <= '0;
            word_buf  <= '0;
            word_cnt  <= '0;
            gap_cnt   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (gap_run && !bus.io_data_valid) gap_cnt <= gap_cnt + GAP_W'(1);
            else                               gap_cnt <= '0;
            if (take_len_lo) len_lo <= bus.io_data_packet;
            if (take_len_hi) len    <= len_in;
            if (take_payload) begin
                byte_idx <= byte_idx + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                csum     <= csum ^ bus.io_data_packet;
`endif
                case (byte_idx)
                    2'd0:    word_buf[7:0]   <= bus.io_data_packet;
                    2'd1:    word_buf[15:8]  <= bus.io_data_packet;
                    2'd2:    word_buf[23:16] <= bus.io_data_packet;
                    default: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                        mem_wdata <= {bus.io_data_packet, word_buf};
                        word_cnt  <= word_cnt + 17'd1;
                    end
                endcase
            end
            if (rearm) begin
                byte_idx <= '0;
                word_cnt <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader: directed and randomized frames checked
// against a frame-level reference model of the loader.
module tb_uart_boot_loader;
    localparam int AW = 6;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic reset_n;

    uart_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    uart_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int cycle      = 0;

    int unsigned obsAddr[$];
    logic [31:0] obsData[$];
    int          lastWeCycle   = -1;
    int          doneRiseCycle = -1;
    logic        prevDone      = 1'b0;

    logic [7:0]  frameQ[$];
    int unsigned expAddr[$];
    logic [31:0] expData[$];
    logic        expDone, expError;

    // Cycle counter used to time the done rise against the last write
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: record every write pulse and the cycle done rises
    always @(negedge clk) begin
        if (bus.io_mem_we === 1'b1) begin
            obsAddr.push_back(int'(bus.io_mem_addr));
            obsData.push_back(bus.io_mem_wdata);
            lastWeCycle = cycle;
        end
        if (bus.io_load_done === 1'b1 && !prevDone) doneRiseCycle = cycle;
        prevDone = (bus.io_load_done === 1'b1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk); #1;
        bus.io_data_valid  = 1'b1;
        bus.io_data_packet = b;
        @(posedge clk); #1;
        bus.io_data_valid  = 1'b0;
    endtask

    task automatic pulseStart();
        @(posedge clk); #1;
        bus.io_load_start = 1'b1;
        @(posedge clk); #1;
        bus.io_load_start = 1'b0;
    endtask

    task automatic clearObs();
        obsAddr.delete();
        obsData.delete();
        lastWeCycle   = -1;
        doneRiseCycle = -1;
    endtask

    // Random frame of n words; the checksum byte is corrupted when badSum is set
    task automatic buildFrame(input int n, input bit badSum);
        logic [7:0] x;
        logic [7:0] r;
        frameQ.delete();
        frameQ.push_back(n[7:0]);
        frameQ.push_back(n[15:8]);
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            r = 8'($urandom);
            frameQ.push_back(r);
            x ^= r;
        end
`ifdef UART_LOADER_CHECKSUM_EN
        frameQ.push_back(badSum ? (x ^ 8'h5A) : x);
`else
        if (badSum) frameQ.push_back(x);
`endif
    endtask

    // Reference: what a loader must do with the whole frame in frameQ
    task automatic modelFrame();
        int         n;
        logic [7:0] x;
        expAddr.delete();
        expData.delete();
        expDone  = 1'b0;
        expError = 1'b0;
        n = int'({frameQ[1], frameQ[0]});
        if (n > (1 << AW)) begin
            expError = 1'b1;
            return;
        end
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            expAddr.push_back(w);
            expData.push_back({frameQ[2+4*w+3], frameQ[2+4*w+2], frameQ[2+4*w+1], frameQ[2+4*w]});
            for (int k = 0; k < 4; k++) x ^= frameQ[2+4*w+k];
        end
`ifdef UART_LOADER_CHECKSUM_EN
        if ((x ^ frameQ[2+4*n]) == 8'h00) expDone = 1'b1;
        else                               expError = 1'b1;
`else
        expDone = 1'b1;
`endif
    endtask

    task automatic sendBytes(input int first, input int last);
        for (int i = first; i <= last && i < frameQ.size(); i++) applyStimulus(frameQ[i]);
    endtask

    task automatic compareFrame(input string tag);
        int m;
        waitCycles(6);
        checkOutput({tag, " writes"}, obsAddr.size(), expAddr.size());
        m = (obsAddr.size() < expAddr.size()) ? obsAddr.size() : expAddr.size();
        for (int i = 0; i < m; i++) begin
            checkOutput($sformatf("%s addr%0d", tag, i), obsAddr[i], expAddr[i]);
            checkOutput($sformatf("%s data%0d", tag, i), obsData[i], expData[i]);
        end
        checkOutput({tag, " done"},        bus.io_load_done,  expDone);
        checkOutput({tag, " error"},       bus.io_load_error, expError);
        checkOutput({tag, " cpu_reset_n"}, bus.io_cpu_reset_n, expDone);
`ifndef UART_LOADER_CHECKSUM_EN
        if (expDone && expAddr.size() > 0)
            checkOutput({tag, " done_timing"}, doneRiseCycle, lastWeCycle + 1);
`endif
    endtask

    task automatic runFrame(input string tag);
        clearObs();
        modelFrame();
        sendBytes(0, frameQ.size() - 1);
        compareFrame(tag);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " we"},          bus.io_mem_we,     1'b0);
        checkOutput({tag, " addr"},        bus.io_mem_addr,   '0);
        checkOutput({tag, " wdata"},       bus.io_mem_wdata,  32'h0);
        checkOutput({tag, " done"},        bus.io_load_done,  1'b0);
        checkOutput({tag, " error"},       bus.io_load_error, 1'b0);
        checkOutput({tag, " cpu_reset_n"}, bus.io_cpu_reset_n, 1'b0);
    endtask

    // Directed sequence with randomized payloads and byte gaps
    initial begin
        bus.io_data_valid  = 1'b0;
        bus.io_data_packet = 8'h00;
        bus.io_load_start  = 1'b0;
        reset_n            = 1'b0;
        #1;
        checkAllZero("reset_asserted");
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        waitCycles(2);
        checkAllZero("reset_released");

        // Two-word image
        frameQ = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef UART_LOADER_CHECKSUM_EN
        frameQ.push_back(8'h7C);
`endif
        runFrame("basic");

        // Bytes arriving in DONE are dropped
        clearObs();
        applyStimulus(8'h05);
        applyStimulus(8'h00);
        waitCycles(4);
        checkOutput("done_discard writes", obsAddr.size(), 0);
        checkOutput("done_discard done", bus.io_load_done, 1'b1);

        // Start and byte together: start wins, byte lost
        @(posedge clk); #1;
        bus.io_load_start  = 1'b1;
        bus.io_data_valid  = 1'b1;
        bus.io_data_packet = 8'h03;
        @(posedge clk); #1;
        bus.io_load_start  = 1'b0;
        bus.io_data_valid  = 1'b0;
        checkOutput("rearm done",        bus.io_load_done,  1'b0);
        checkOutput("rearm error",       bus.io_load_error, 1'b0);
        checkOutput("rearm cpu_reset_n", bus.io_cpu_reset_n, 1'b0);

        // Zero-length image
        frameQ = '{8'h00, 8'h00};
`ifdef UART_LOADER_CHECKSUM_EN
        frameQ.push_back(8'h00);
`endif
        runFrame("len_zero");
        pulseStart();

        // Oversized images
        frameQ = '{8'h01, 8'h04};
        runFrame("len_0401");
        pulseStart();
        frameQ = '{8'h41, 8'h00};
        runFrame("len_cap_plus1");
        pulseStart();

        // Image filling the whole memory
        buildFrame(1 << AW, 1'b0);
        runFrame("len_cap");
        pulseStart();

        // Random images
        for (int f = 0; f < 4; f++) begin
            buildFrame(int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
`ifndef UART_LOADER_CHECKSUM_EN
            if (frameQ.size() > 2 + 4 * int'({frameQ[1], frameQ[0]})) void'(frameQ.pop_back());
`endif
            runFrame($sformatf("random%0d", f));
            pulseStart();
        end

        // Start pulse while loading is ignored
        buildFrame(3, 1'b0);
        clearObs();
        modelFrame();
        sendBytes(0, 6);
        pulseStart();
        sendBytes(7, frameQ.size() - 1);
        compareFrame("start_ignored");
        pulseStart();

        // Idle in LEN_LO never times out
        waitCycles(TO + 10);
        checkOutput("idle_len_lo error", bus.io_load_error, 1'b0);

        // Timeout with a partial word
        clearObs();
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        waitCycles(TO - 10);
        checkOutput("timeout_early error", bus.io_load_error, 1'b0);
        waitCycles(20);
        checkOutput("timeout error",       bus.io_load_error, 1'b1);
        checkOutput("timeout writes",      obsAddr.size(), 0);
        checkOutput("timeout cpu_reset_n", bus.io_cpu_reset_n, 1'b0);
        pulseStart();
        buildFrame(2, 1'b0);
        runFrame("after_timeout");
        pulseStart();

        // Reset in the middle of the payload
        buildFrame(2, 1'b0);
        sendBytes(0, 6);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        checkAllZero("mid_reset");
        @(posedge clk);
        #2 reset_n = 1'b1;
        buildFrame(2, 1'b0);
        runFrame("after_reset");

`ifdef UART_LOADER_CHECKSUM_EN
        pulseStart();
        frameQ = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        runFrame("csum_good");
        pulseStart();
        frameQ = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
        runFrame("csum_bad");
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
